// File: rtl/fpmul_sched_pkg.sv
// Shared types and constants for the FPMUL round-robin scheduler.
package fpmul_sched_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   localparam int FLAGS_W   = 6;
   localparam int FLAG_UF   = 0;
   localparam int FLAG_OF   = 1;
   localparam int FLAG_NANF = 2;
   localparam int FLAG_INFF = 3;
   localparam int FLAG_DNF  = 4;
   localparam int FLAG_ZF   = 5;

   // Never returns less than 1 so a degenerate range still gets a real vector.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/fpmul_sched_if.sv
// Requester-side and FPMUL-side signals of the scheduler, bundled for port use.
interface fpmul_sched_if #(
   parameter int N_REQ = 4
) ();
   import fpmul_sched_pkg::*;

   logic [N_REQ-1:0]    Req;
   logic [32*N_REQ-1:0] A_in;
   logic [32*N_REQ-1:0] B_in;
   logic [N_REQ-1:0]    Gnt;
   logic [N_REQ-1:0]    Rsp_Vld;
   logic [31:0]         Rsp_P;
   logic [FLAGS_W-1:0]  Rsp_Flags;
   logic                Rsp_Err;
   logic                Busy;
   logic                Mul_Start;
   logic [31:0]         Mul_A;
   logic [31:0]         Mul_B;
   logic                Mul_Rst;
   logic                Mul_Done;
   logic [31:0]         Mul_P;
   logic [FLAGS_W-1:0]  Mul_Flags;

   // master: the scheduler; slave: requesters plus the FPMUL instance
   modport master (
      input  Req, A_in, B_in, Mul_Done, Mul_P, Mul_Flags,
      output Gnt, Rsp_Vld, Rsp_P, Rsp_Flags, Rsp_Err, Busy,
             Mul_Start, Mul_A, Mul_B, Mul_Rst
   );

   modport slave (
      output Req, A_in, B_in, Mul_Done, Mul_P, Mul_Flags,
      input  Gnt, Rsp_Vld, Rsp_P, Rsp_Flags, Rsp_Err, Busy,
             Mul_Start, Mul_A, Mul_B, Mul_Rst
   );

endinterface

// File: rtl/fpmul_rr_arb.sv
// Combinational round-robin picker: first request at or above the pointer, else lowest overall.
module fpmul_rr_arb
   import fpmul_sched_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int PW    = clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [PW-1:0]    ptr_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic             vld_o
);

   logic [N_REQ-1:0] hi;
   logic [N_REQ-1:0] pick;
   logic             found;

   always_comb begin
      hi = '0;
      for (int j = 0; j < N_REQ; j++) begin
         hi[j] = req_i[j] && (j >= int'(ptr_i));
      end
      // Nothing at or above the pointer means the search wraps to index 0.
      pick  = (|hi) ? hi : req_i;
      gnt_o = '0;
      found = 1'b0;
      for (int j = 0; j < N_REQ; j++) begin
         if (pick[j] && !found) begin
            gnt_o[j] = 1'b1;
            found    = 1'b1;
         end
      end
      vld_o = |req_i;
   end

endmodule

// File: rtl/fpmul_sched.sv
// Shares one FPMUL among N_REQ requesters: grant, issue, wait (with watchdog), respond.
module fpmul_sched
   import fpmul_sched_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic          Clk,
   input  logic          Rst,
   fpmul_sched_if.master bus
);

   localparam int PW = clog2(N_REQ);
   localparam int CW = clog2(TIMEOUT + 1);

   state_e             state_q, state_d;
   logic [PW-1:0]      ptr_q, ptr_d;
   logic [PW-1:0]      win_q, win_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic [N_REQ-1:0]   rsp_vld_q, rsp_vld_d;
   logic               start_q, start_d;
   logic               mul_rst_q, mul_rst_d;
   logic [31:0]        mul_a_q, mul_a_d;
   logic [31:0]        mul_b_q, mul_b_d;
   logic [31:0]        rsp_p_q, rsp_p_d;
   logic [FLAGS_W-1:0] rsp_flags_q, rsp_flags_d;
   logic               rsp_err_q, rsp_err_d;

   logic [N_REQ-1:0]   arb_oh;
   logic               arb_vld;
   logic [PW-1:0]      arb_idx;
   logic [31:0]        a_sel, b_sel;
   logic [CW-1:0]      cnt_inc;

   fpmul_rr_arb #(.N_REQ(N_REQ), .PW(PW)) u_arb (
      .req_i (bus.Req),
      .ptr_i (ptr_q),
      .gnt_o (arb_oh),
      .vld_o (arb_vld)
   );

   always_comb begin
      arb_idx = '0;
      a_sel   = '0;
      b_sel   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (arb_oh[i]) begin
            arb_idx = PW'(i);
            a_sel   = bus.A_in[i*32 +: 32];
            b_sel   = bus.B_in[i*32 +: 32];
         end
      end
   end

   assign cnt_inc = cnt_q + CW'(1);

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      win_d       = win_q;
      cnt_d       = cnt_q;
      gnt_d       = '0;
      rsp_vld_d   = '0;
      start_d     = 1'b0;
      mul_rst_d   = 1'b1;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      rsp_p_d     = rsp_p_q;
      rsp_flags_d = rsp_flags_q;
      rsp_err_d   = rsp_err_q;
      unique case (state_q)
         IDLE: begin
            if (arb_vld) begin
               gnt_d   = arb_oh;
               mul_a_d = a_sel;
               mul_b_d = b_sel;
               win_d   = arb_idx;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            // Mul_Done is deliberately not looked at here: a stale level from the last op is masked.
            start_d = 1'b1;
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_inc;
            if (bus.Mul_Done) begin
               rsp_p_d     = bus.Mul_P;
               rsp_flags_d = bus.Mul_Flags;
               rsp_err_d   = 1'b0;
               rsp_vld_d   = N_REQ'(1) << win_q;
               state_d     = RESP;
            end else if (cnt_inc == CW'(TIMEOUT)) begin
               mul_rst_d   = 1'b0;
               rsp_p_d     = QNAN;
               rsp_flags_d = '0;
               rsp_err_d   = 1'b1;
               rsp_vld_d   = N_REQ'(1) << win_q;
               state_d     = RESP;
            end
         end
         RESP: begin
            ptr_d   = (win_q == PW'(N_REQ - 1)) ? '0 : win_q + PW'(1);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         win_q       <= '0;
         cnt_q       <= '0;
         gnt_q       <= '0;
         rsp_vld_q   <= '0;
         start_q     <= 1'b0;
         mul_rst_q   <= 1'b0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         rsp_p_q     <= '0;
         rsp_flags_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         win_q       <= win_d;
         cnt_q       <= cnt_d;
         gnt_q       <= gnt_d;
         rsp_vld_q   <= rsp_vld_d;
         start_q     <= start_d;
         mul_rst_q   <= mul_rst_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         rsp_p_q     <= rsp_p_d;
         rsp_flags_q <= rsp_flags_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign bus.Gnt       = gnt_q;
   assign bus.Rsp_Vld   = rsp_vld_q;
   assign bus.Rsp_P     = rsp_p_q;
   assign bus.Rsp_Flags = rsp_flags_q;
   assign bus.Rsp_Err   = rsp_err_q;
   assign bus.Busy      = (state_q != IDLE);
   assign bus.Mul_Start = start_q;
   assign bus.Mul_A     = mul_a_q;
   assign bus.Mul_B     = mul_b_q;
   assign bus.Mul_Rst   = mul_rst_q;

endmodule

// File: doc/fpmul_sched.md
Name: fpmul_sched

Overview:
- Round-robin scheduler that shares one FPMUL instance among N_REQ requesters.
- Per transaction it grants one requester, captures its operands, pulses Start, waits for Done and returns product plus flags to the winner.
- A watchdog aborts and resets the multiplier if Done never arrives.
- Sits between requester clients (e.g. FPU issue logic) and the FPMUL top.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- TIMEOUT, 255, max WAIT cycles before abort (1..65535)

Ports:
- Clk  in  1  system clock, rising edge
- Rst  in  1  reset, synchronous, active-low
- Req  in  N_REQ  per-requester request level
- A_in  in  32*N_REQ  operand A, slice i belongs to requester i
- B_in  in  32*N_REQ  operand B, slice i
- Gnt  out  N_REQ  one-hot grant, one-cycle pulse at capture
- Rsp_Vld  out  N_REQ  one-hot response-valid pulse to winner
- Rsp_P  out  32  product (valid with Rsp_Vld)
- Rsp_Flags  out  6  {ZF,DNF,InfF,NaNF,OF,UF} (bits 5..0)
- Rsp_Err  out  1  timeout abort indicator, valid with Rsp_Vld
- Busy  out  1  high in any state but IDLE
- Mul_Start  out  1  Start pulse to FPMUL
- Mul_A  out  32  registered operand A to FPMUL
- Mul_B  out  32  registered operand B to FPMUL
- Mul_Rst  out  1  FPMUL reset, active-low, one-cycle low on abort
- Mul_Done  in  1  FPMUL Done
- Mul_P  in  32  FPMUL product
- Mul_Flags  in  6  {ZF,DNF,InfF,NaNF,OF,UF} from FPMUL

Behaviour:
- Reset (Rst low at edge), takes effect at the next edge:
  - state IDLE; RR pointer 0; counter 0.
  - Gnt, Rsp_Vld, Rsp_Err, Busy, Mul_Start = 0; Mul_Rst = 0 while Rst low, then 1.
  - Mul_A, Mul_B, Rsp_P = 0; Rsp_Flags = 0.
- State IDLE:
  - If any Req, pick the winner: first set bit at or after the RR pointer, wrapping modulo N_REQ.
  - Pulse Gnt[winner]; register A_in/B_in slices into Mul_A/Mul_B; store winner index; go ISSUE.
  - No Req: stay IDLE.
- State ISSUE (1 cycle): Mul_Start=1; counter cleared; go WAIT. Mul_Done in this cycle is ignored.
- State WAIT: counter increments each cycle.
  - Mul_Done=1: register Mul_P to Rsp_P and Mul_Flags to Rsp_Flags; Rsp_Err=0; go RESP.
  - Counter reaches TIMEOUT without Done: Mul_Rst=0 for one cycle; Rsp_P=0x7FC00000; Rsp_Flags=0; Rsp_Err=1; go RESP.
  - Done and timeout in the same cycle: Done wins.
- State RESP (1 cycle):
  - Rsp_Vld[winner]=1; RR pointer = winner+1 mod N_REQ; go IDLE.
  - Rsp_P, Rsp_Flags, Rsp_Err hold until the next RESP.
- Latency:
  - Req to Gnt: 1 cycle from an idle scheduler.
  - Gnt to Mul_Start: 1 cycle.
  - Mul_Done to Rsp_Vld: 1 cycle.
  - Minimum spacing between successive grants: 4 cycles plus FPMUL latency.
- Handshake:
  - Operands are sampled only in the Gnt cycle.
  - Dropping Req after Gnt does not cancel the operation; Rsp_Vld is still issued.
  - Req still high after Rsp_Vld counts as a new request, ranked behind the others by the pointer.
- Mul_Done is level-sampled only in WAIT. A Done held high from a prior operation is masked because ISSUE ignores Done.
- Reset mid-operation: abandon the transaction with no Rsp_Vld. Mul_Rst is driven low so FPMUL is also cleared.
- Only one outstanding FPMUL operation at any time; Busy=1 throughout.
- Gnt and Rsp_Vld are at most one-hot and never high together.

Decomposition:
- Package fpmul_sched_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP}
  - QNAN constant 32'h7FC00000
  - flag bit index constants (UF=0 .. ZF=5)
  - function clog2 for pointer/counter widths
- Sub-module fpmul_rr_arb: combinational round-robin picker.
  - Inputs: Req and the pointer.
  - Outputs: one-hot winner and a valid flag.
  - Instantiated once.

Test Plan:
- Single requester 0: A=0x40000000, B=0x40400000, FPMUL model Done after 30 cycles -> Gnt[0] 1 cycle after Req; Mul_Start next cycle; Rsp_Vld[0] with Rsp_P=0x40C00000, Rsp_Flags=0, Rsp_Err=0.
- All four Req high continuously, pointer 0 -> grant order 0,1,2,3,0; each Rsp_Vld one-hot to the matching index; no grant overlaps an active transaction.
- Model never asserts Done, TIMEOUT=255 -> exactly 255 WAIT cycles; Mul_Rst low 1 cycle; Rsp_Vld[winner] with Rsp_P=0x7FC00000, Rsp_Err=1; next request served normally.
- Done held high from the previous op into ISSUE -> ignored; response only after Done is seen in WAIT (model deasserts, then reasserts).
- Rst low for 1 cycle during WAIT on requester 2 -> no Rsp_Vld[2]; all outputs at reset values; pointer 0; fresh Req[1] then granted first.
- Requester 1 drops Req the cycle after Gnt, model gives 0x3F800000*0x00000000 -> Rsp_Vld[1] still pulses with Rsp_P=0x00000000, Rsp_Flags bit5 (ZF)=1.
